fft_sched: RTL and testbench
============================

# fft_sched

Butterfly sequencer for the 16-point radix-2 DIT FFT, mapped on the openMSP430 peripheral bus. Firmware loads samples in bit-reversed order into the butterfly unit's sample RAM and writes START. The block then issues all 32 butterflies (4 stages × 8) to the external butterfly datapath through a req/ack handshake, and drains the datapath between stages. It reports completion through a status register and a level interrupt. Its per_dout is ORed into the CPU per_dout bus alongside the other peripherals.

## Interface
- BASE_ADDR, 15'h0100: byte base address; block decodes 3 word registers at BASE_ADDR+0/2/4.
- mclk  in  1  main system clock.
- reset_n  in  1  asynchronous active-low reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  write data.
- per_en  in  1  peripheral access enable.
- per_we  in  2  byte write enables; [0]=low byte, [1]=high byte.
- per_dout  out  16  read data; 0 when not addressed or on a write.
- irq_fft  out  1  interrupt, level = DONE & IE.
- bf_req  out  1  butterfly request.
- bf_addr_a  out  4  sample index of the upper leg.
- bf_addr_b  out  4  sample index of the lower leg.
- bf_tw  out  3  twiddle index k for W16^k.
- bf_inv  out  1  inverse-transform flag (CTRL.INV latched at START).
- bf_ack  in  1  single-cycle accept of the current request.
- bf_idle  in  1  datapath has no butterflies in flight.

## Operation
- Registers (word offset):
  - 0 CTRL: [0] START (write-1 pulse, reads 0); [1] ABORT (write-1 pulse, reads 0); [2] IE; [3] INV.
  - 1 STATUS: [0] BUSY; [1] DONE (sticky, write 1 clears); [5:4] stage; [10:8] butterfly k.
  - 2 CYCLES: read-only mclk count of the current or last run.
- A register is selected when per_en is high and per_addr[13:2] equals BASE_ADDR[14:3]; per_addr[1:0] picks the register, and value 3 reads 0. Writes to bits in an unwritten byte lane are ignored.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: a START write latches INV, clears DONE and CYCLES, sets stage=0 and k=0, and moves to ISSUE.
  - ISSUE: bf_req=1, with addresses driven from stage s and k:
    - span = 1<<s; pos = k & (span-1); grp = k >> s.
    - a = grp·2·span + pos; b = a + span; tw = pos << (3-s).
    - On bf_ack with k<7: k increments and req stays high with new addresses the next cycle.
    - On bf_ack with k=7 and s<3: go to DRAIN.
    - On bf_ack with k=7 and s=3: go to FINISH.
  - DRAIN: bf_req=0. When bf_idle=1, set stage=s+1 and k=0, then go to ISSUE.
  - FINISH: bf_req=0. Wait for bf_idle=1, then set DONE and return to IDLE.
- BUSY = (state ≠ IDLE).
- START while BUSY is ignored.
- ABORT while BUSY: next state is IDLE, bf_req drops, DONE is not set, and stage/k hold their values for debug.
- START and ABORT written in the same cycle: ABORT wins, so START is ignored.
- DONE-clear and DONE-set in the same cycle: set wins.
- CYCLES increments on every mclk while BUSY and saturates at 16'hFFFF.

## Timing
- Reset values:
  - All registers 0; state IDLE.
  - bf_req=0, bf_addr_a=0, bf_addr_b=1, bf_tw=0, bf_inv=0.
  - irq_fft=0, per_dout=0.
- per_dout is combinational from per_en/per_addr; reads have zero wait states.
- START written in cycle n: BUSY=1 and bf_req=1 with a=0, b=1 in cycle n+1.
- All handshake outputs are registered. Addresses are stable while bf_req=1 and bf_ack=0.
- Ack-to-next-request takes one cycle. bf_ack while bf_req=0 is ignored.
- Minimum run, with bf_ack tied high and bf_idle tied high:
  - 32 ISSUE cycles, 3 DRAIN cycles and 1 FINISH cycle; CYCLES reads 36.
  - DONE and irq_fft are high 37 cycles after the START write.
- reset_n asserted mid-run: all outputs return to reset values immediately (asynchronously). No partial state survives.

## Test plan
- Reset, then read all offsets -> 0x0000 each; bf_req=0, irq_fft=0.
- Set IE=1, START, with bf_ack=1 and bf_idle=1 constant -> 32 requests with (a,b,tw):
  - stage 0: (0,1,0), (2,3,0) … (14,15,0);
  - stage 1: (0,2,0), (1,3,4) …;
  - stage 3: (0,8,0) … (7,15,7).
  - Then DONE=1, irq_fft=1, CYCLES=36.
- Hold bf_ack low 5 cycles on butterfly 3 -> addresses are held for those 5 cycles, then CYCLES=41. Hold bf_idle low 4 cycles at the stage-1 boundary -> no request issued until bf_idle rises.
- ABORT at stage 2, k=4 -> IDLE next cycle, bf_req=0, DONE=0, STATUS reads 0x0420. A subsequent START runs a full clean transform.
- START while BUSY -> no restart and CYCLES not cleared. Write 0x0002 to STATUS after done -> DONE=0 and irq_fft=0. A byte write to CTRL with per_we=2'b10 -> no effect.
- Assert reset_n mid-ISSUE -> bf_req=0 and STATUS=0 without a clock edge.

Source files
------------

// File: rtl/fft_sched.sv
// Purpose: butterfly sequencer for a 16-point radix-2 DIT FFT, openMSP430 peripheral.
// Latency: START write in cycle n gives the first bf_req in n+1; minimum run is 36 busy cycles.
// Backpressure: bf_req and the addresses hold until bf_ack; stage boundaries wait for bf_idle.
module fft_sched #(
    parameter logic [14:0] BASE_ADDR = 15'h0100
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq_fft,
    output logic        bf_req,
    output logic [3:0]  bf_addr_a,
    output logic [3:0]  bf_addr_b,
    output logic [2:0]  bf_tw,
    output logic        bf_inv,
    input  logic        bf_ack,
    input  logic        bf_idle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  stage;
    logic [2:0]  k;
    logic        done;
    logic        ie;
    logic        inv_cfg;
    logic [15:0] cycles;

    logic        reg_sel;
    logic        ctrl_wr_lo;
    logic        status_wr_lo;
    logic        start_req;
    logic        abort_req;
    logic        done_clr;
    logic        busy;
    logic        unused_bits;

    // All live register bits sit in the low byte; the high byte only carries read data.
    assign unused_bits  = ^{per_din[15:4], per_we[1]};

    assign reg_sel      = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
    assign ctrl_wr_lo   = reg_sel && per_we[0] && (per_addr[1:0] == 2'd0);
    assign status_wr_lo = reg_sel && per_we[0] && (per_addr[1:0] == 2'd1);
    assign start_req    = ctrl_wr_lo && per_din[0];
    assign abort_req    = ctrl_wr_lo && per_din[1];
    assign done_clr     = status_wr_lo && per_din[1];
    assign busy         = (state != ST_IDLE);
    assign irq_fft      = done && ie;

    // Leg addresses and twiddle for butterfly k of stage s, packed as {a, b, tw}.
    function automatic logic [10:0] bf_map(input logic [1:0] s, input logic [2:0] kk);
        logic [3:0] k4;
        logic [3:0] span;
        logic [3:0] pos;
        logic [3:0] grp;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
        k4   = {1'b0, kk};
        span = 4'd1 << s;
        pos  = k4 & (span - 4'd1);
        grp  = k4 >> s;
        a    = ((grp << s) << 1) | pos;
        b    = a + span;
        tw   = pos[2:0] << (2'd3 - s);
        return {a, b, tw};
    endfunction

    // Configuration bits written through the CTRL low byte.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            ie      <= 1'b0;
            inv_cfg <= 1'b0;
        end else if (ctrl_wr_lo) begin
            ie      <= per_din[2];
            inv_cfg <= per_din[3];
        end
    end

    // Sequencer FSM with registered handshake outputs, DONE flag and run-cycle counter.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            stage     <= 2'd0;
            k         <= 3'd0;
            done      <= 1'b0;
            cycles    <= 16'd0;
            bf_req    <= 1'b0;
            bf_addr_a <= 4'd0;
            bf_addr_b <= 4'd1;
            bf_tw     <= 3'd0;
            bf_inv    <= 1'b0;
        end else begin
            // A clear request is overridden below if DONE is set in the same cycle.
            if (done_clr) begin
                done <= 1'b0;
            end
            if (busy && (cycles != 16'hFFFF)) begin
                cycles <= cycles + 16'd1;
            end

            if (busy && abort_req) begin
                // stage/k and the addresses are left as they were for debug.
                state  <= ST_IDLE;
                bf_req <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_req && !abort_req) begin
                            state  <= ST_ISSUE;
                            bf_inv <= per_din[3];
                            done   <= 1'b0;
                            cycles <= 16'd0;
                            stage  <= 2'd0;
                            k      <= 3'd0;
                            bf_req <= 1'b1;
                            {bf_addr_a, bf_addr_b, bf_tw} <= bf_map(2'd0, 3'd0);
                        end
                    end
                    ST_ISSUE: begin
                        if (bf_ack) begin
                            if (k != 3'd7) begin
                                k <= k + 3'd1;
                                {bf_addr_a, bf_addr_b, bf_tw} <= bf_map(stage, k + 3'd1);
                            end else begin
                                bf_req <= 1'b0;
                                state  <= (stage == 2'd3) ? ST_FINISH : ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (bf_idle) begin
                            stage  <= stage + 2'd1;
                            k      <= 3'd0;
                            bf_req <= 1'b1;
                            state  <= ST_ISSUE;
                            {bf_addr_a, bf_addr_b, bf_tw} <= bf_map(stage + 2'd1, 3'd0);
                        end
                    end
                    ST_FINISH: begin
                        if (bf_idle) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        bf_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Zero-wait-state read mux; drives 0 unless this block is addressed by a read.
    always_comb begin
        per_dout = 16'd0;
        if (reg_sel && (per_we == 2'b00)) begin
            case (per_addr[1:0])
                2'd0:    per_dout = {12'd0, inv_cfg, ie, 2'b00};
                2'd1:    per_dout = {5'd0, k, 2'b00, stage, 2'b00, done, busy};
                2'd2:    per_dout = cycles;
                default: per_dout = 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sched.sv
// Purpose: randomized self-checking bench for fft_sched against a butterfly-list/timing model.
// Latency: model predicts per-cycle bf_req, accepted (a,b,tw), DONE cycle and CYCLES.
// Backpressure: bf_ack/bf_idle driven from per-cycle patterns fixed before each run.
module tb_fft_sched;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] per_addr = 14'd0;
    logic [15:0] per_din = 16'd0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout;
    logic        irq_fft;
    logic        bf_req;
    logic [3:0]  bf_addr_a;
    logic [3:0]  bf_addr_b;
    logic [2:0]  bf_tw;
    logic        bf_inv;
    logic        bf_ack = 1'b0;
    logic        bf_idle = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    bit ack_pat [0:511];
    bit idle_pat[0:511];
    bit exp_req [0:511];
    int exp_a   [0:31];
    int exp_b   [0:31];
    int exp_tw  [0:31];

    localparam logic [13:0] WBASE = 14'h0080;

    fft_sched #(.BASE_ADDR(15'h0100)) dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout),
        .irq_fft   (irq_fft),
        .bf_req    (bf_req),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .bf_tw     (bf_tw),
        .bf_inv    (bf_inv),
        .bf_ack    (bf_ack),
        .bf_idle   (bf_idle)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; the write is captured at the next posedge.
    task automatic wr(input logic [1:0] ofs, input logic [15:0] d, input logic [1:0] we);
        per_en   = 1'b1;
        per_addr = WBASE | {12'd0, ofs};
        per_din  = d;
        per_we   = we;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic rd(input logic [1:0] ofs, output logic [15:0] v);
        per_en   = 1'b1;
        per_addr = WBASE | {12'd0, ofs};
        per_we   = 2'b00;
        #1;
        v = per_dout;
        per_en = 1'b0;
    endtask

    // Butterfly order as groups of span-separated pairs, twiddle step 8/span.
    task automatic build_list();
        int idx = 0;
        for (int s = 0; s < 4; s++) begin
            int span = 1 << s;
            for (int g = 0; g < (8 / span); g++) begin
                for (int p = 0; p < span; p++) begin
                    exp_a[idx]  = g * 2 * span + p;
                    exp_b[idx]  = g * 2 * span + p + span;
                    exp_tw[idx] = p * (8 / span);
                    idx++;
                end
            end
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 512; i++) begin
            ack_pat[i]  = 1'b1;
            idle_pat[i] = 1'b1;
        end
    endtask

    // Full transform: START with IE, optional ignored re-START at cycle restart_at.
    task automatic run_fft(input logic inv, input int restart_at);
        int t = 1;
        int t_end;
        int n_acc = 0;
        logic [15:0] v;
        for (int i = 0; i < 512; i++) exp_req[i] = 1'b0;
        // Timing model: each butterfly waits for ack; each stage end waits for idle.
        for (int s = 0; s < 4; s++) begin
            for (int kk = 0; kk < 8; kk++) begin
                while (!ack_pat[t]) begin
                    exp_req[t] = 1'b1;
                    t++;
                end
                exp_req[t] = 1'b1;
                t++;
            end
            while (!idle_pat[t]) t++;
            t++;
        end
        t_end = t;

        bf_ack = 1'b0;
        wr(2'd0, 16'h0005 | {12'd0, inv, 3'b000}, 2'b11);
        for (int c = 1; c <= t_end; c++) begin
            bf_ack  = ack_pat[c];
            bf_idle = idle_pat[c];
            if (c == restart_at) begin
                per_en   = 1'b1;
                per_addr = WBASE;
                per_din  = 16'h0005 | {12'd0, inv, 3'b000};
                per_we   = 2'b11;
            end
            @(negedge mclk);
            check("bf_req", bf_req, exp_req[c]);
            check("irq_timing", irq_fft, (c == t_end));
            if (c == 1) check("bf_inv", bf_inv, inv);
            if (exp_req[c] && n_acc < 32) begin
                check("addr_a", bf_addr_a, exp_a[n_acc]);
                check("addr_b", bf_addr_b, exp_b[n_acc]);
                check("tw", bf_tw, exp_tw[n_acc]);
                if (bf_ack) n_acc++;
            end
            @(posedge mclk);
            #1;
            per_en = 1'b0;
            per_we = 2'b00;
        end
        bf_ack = 1'b0;
        check("n_accepted", n_acc, 32);
        rd(2'd2, v);
        check("cycles", v, t_end - 1);
        rd(2'd1, v);
        check("status_done", v, (7 << 8) | (3 << 4) | 2);
    endtask

    initial begin
        logic [15:0] v;
        logic        inv;
        build_list();

        // Reset
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        @(posedge mclk);
        #1;
        for (int o = 0; o < 4; o++) begin
            rd(o[1:0], v);
            check("reset_reg", v, 0);
        end
        check("reset_req", bf_req, 0);
        check("reset_irq", irq_fft, 0);
        check("reset_addr_b", bf_addr_b, 1);

        wr(2'd0, 16'h0004, 2'b11);
        rd(2'd0, v);
        check("ctrl_ie", v, 16'h0004);

        // Minimum run
        fill_ones();
        run_fft(1'b0, -1);

        // Ack held low for 5 cycles on butterfly 3
        fill_ones();
        for (int i = 4; i <= 8; i++) ack_pat[i] = 1'b0;
        run_fft(1'b0, -1);

        // Idle held low for 4 cycles at the first stage boundary
        fill_ones();
        for (int i = 9; i <= 12; i++) idle_pat[i] = 1'b0;
        run_fft(1'b0, -1);

        // ABORT at stage 2, k=4
        wr(2'd0, 16'h0005, 2'b11);
        for (int c = 1; c <= 22; c++) begin
            bf_ack  = 1'b1;
            bf_idle = 1'b1;
            @(posedge mclk);
            #1;
        end
        bf_ack = 1'b0;
        @(negedge mclk);
        check("abort_pre_req", bf_req, 1);
        check("abort_pre_a", bf_addr_a, exp_a[20]);
        check("abort_pre_b", bf_addr_b, exp_b[20]);
        wr(2'd0, 16'h0006, 2'b11);
        check("abort_req", bf_req, 0);
        rd(2'd1, v);
        check("abort_status", v, 16'h0420);
        check("abort_irq", irq_fft, 0);
        rd(2'd2, v);
        check("abort_cycles", v, 23);
        fill_ones();
        run_fft(1'b0, -1);

        // START while busy is ignored
        fill_ones();
        run_fft(1'b1, 5);

        // DONE clear through STATUS
        wr(2'd1, 16'h0002, 2'b11);
        rd(2'd1, v);
        check("done_clr", v, 16'h0730);
        check("done_clr_irq", irq_fft, 0);

        // High-byte-only write to CTRL has no effect
        wr(2'd0, 16'h00FF, 2'b10);
        check("hi_byte_req", bf_req, 0);
        rd(2'd0, v);
        check("hi_byte_ctrl", v, 16'h000C);

        // START together with ABORT: START ignored
        wr(2'd0, 16'h0007, 2'b11);
        check("start_abort_req", bf_req, 0);
        rd(2'd1, v);
        check("start_abort_st", v, 16'h0730);

        // Randomized backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 512; i++) begin
                ack_pat[i]  = (i >= 300) || ($urandom_range(0, 99) < 60);
                idle_pat[i] = (i >= 300) || ($urandom_range(0, 99) < 50);
            end
            inv = 1'($urandom_range(0, 1));
            run_fft(inv, -1);
        end

        // Asynchronous reset mid-ISSUE
        wr(2'd0, 16'h0005, 2'b11);
        bf_ack  = 1'b1;
        bf_idle = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("pre_rst_req", bf_req, 1);
        reset_n = 1'b0;
        #1;
        check("rst_req", bf_req, 0);
        check("rst_irq", irq_fft, 0);
        check("rst_addr_a", bf_addr_a, 0);
        check("rst_addr_b", bf_addr_b, 1);
        check("rst_tw", bf_tw, 0);
        rd(2'd1, v);
        check("rst_status", v, 0);
        bf_ack = 1'b0;
        @(negedge mclk);
        reset_n = 1'b1;
        @(posedge mclk);
        #1;
        rd(2'd2, v);
        check("rst_cycles", v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
